bnn_param_loader: RTL and testbench

//  Sequencer that programs a daisy-chain of binary neurons. It takes host bytes over a valid/ready stream.
//  It serialises them MSB-first onto the chain's setup/param_in shift path.
//  It counts exactly NEURONS*(INPUTS+BIAS_BITS) shift cycles, then drops setup and raises loaded.

---
 rtl/bnn_pkg.sv | 27 ++
 rtl/bnn_param_loader_if.sv | 13 +
 rtl/bnn_byte_serializer.sv | 61 ++++++
 rtl/bnn_param_loader.sv | 101 ++++++++++
 tb/tb_bnn_param_loader.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neuron array and its parameter loader:
// loader state encoding, chain sizing helpers and default array geometry.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } loader_state_e;

    localparam int DEF_NEURONS   = 4;
    localparam int DEF_INPUTS    = 8;
    localparam int DEF_BIAS_BITS = 3;
    localparam int DEF_DATA_W    = 8;

    // Number of serial bits held by the whole chain
    function automatic int total_bits(input int neurons, input int inputs, input int bias_bits);
        return neurons * (inputs + bias_bits);
    endfunction

    // Number of host bytes needed to cover the chain, last one possibly partial
    function automatic int total_bytes(input int neurons, input int inputs, input int bias_bits,
                                       input int data_w);
        return (total_bits(neurons, inputs, bias_bits) + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/bnn_param_loader_if.sv
// Host byte stream into the parameter loader (valid/ready handshake).
interface bnn_param_loader_if
    import bnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/bnn_byte_serializer.sv
// One-byte buffer that turns accepted host bytes into an MSB-first bit stream.
// A new byte may land in the same cycle the last buffered bit leaves, so a
// host that keeps s_valid high sees a gapless 1 bit/clk stream.
module bnn_byte_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              room_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              xfer_o,
    output logic              shift_o,
    output logic              setup_o,
    output logic              param_bit_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  bufCnt_q, bufCnt_d;
    logic              setup_q, paramBit_q;

    assign shift_o     = enable_i && (bufCnt_q != '0);
    assign ready_o     = room_i && ((bufCnt_q == '0) || ((bufCnt_q == CNT_W'(1)) && shift_o));
    assign xfer_o      = ready_o && valid_i;
    assign setup_o     = setup_q;
    assign param_bit_o = paramBit_q;

    // Buffer update: a fresh byte overrides the shift of its predecessor's last bit
    always_comb begin
        sreg_d   = sreg_q;
        bufCnt_d = bufCnt_q;
        if (clear_i) begin
            bufCnt_d = '0;
        end else if (xfer_o) begin
            sreg_d   = data_i;
            bufCnt_d = CNT_W'(DATA_W);
        end else if (shift_o) begin
            sreg_d   = sreg_q << 1;
            bufCnt_d = bufCnt_q - CNT_W'(1);
        end
    end

    // Buffer registers and the registered shift strobe/bit towards the chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q     <= '0;
            bufCnt_q   <= '0;
            setup_q    <= 1'b0;
            paramBit_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            bufCnt_q   <= bufCnt_d;
            setup_q    <= shift_o;
            paramBit_q <= shift_o ? sreg_q[DATA_W-1] : 1'b0;
        end
    end
endmodule

// File: rtl/bnn_param_loader.sv
// Sequencer that shifts a complete parameter set into a daisy-chain of binary
// neurons and flags the chain as loaded once every bit has gone out.
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int NEURONS   = DEF_NEURONS,
    parameter int INPUTS    = DEF_INPUTS,
    parameter int BIAS_BITS = DEF_BIAS_BITS,
    parameter int DATA_W    = DEF_DATA_W,
    localparam int BIT_W    = $clog2(NEURONS * (INPUTS + BIAS_BITS) + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    bnn_param_loader_if.slave   bus,
    output logic                setup_o,
    output logic                param_bit_o,
    output logic                busy_o,
    output logic                loaded_o,
    output logic                run_o,
    output logic [BIT_W-1:0]    bit_cnt_o
);
    localparam int TOTAL_BITS  = total_bits(NEURONS, INPUTS, BIAS_BITS);
    localparam int TOTAL_BYTES = total_bytes(NEURONS, INPUTS, BIAS_BITS, DATA_W);
    localparam int BYTE_W      = $clog2(TOTAL_BYTES + 1);

    loader_state_e     state_q, state_d;
    logic [BIT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [BYTE_W-1:0] byteCnt_q, byteCnt_d;
    logic              startLoad, loadActive, shiftEn, byteRoom, shift, xfer;

    assign loadActive = (state_q == ST_LOAD);
    assign shiftEn    = loadActive && (bitCnt_q < BIT_W'(TOTAL_BITS));
    assign byteRoom   = loadActive && (byteCnt_q < BYTE_W'(TOTAL_BYTES));

    bnn_byte_serializer #(.DATA_W(DATA_W)) u_serializer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (startLoad),
        .enable_i    (shiftEn),
        .room_i      (byteRoom),
        .data_i      (bus.s_data),
        .valid_i     (bus.s_valid),
        .ready_o     (bus.s_ready),
        .xfer_o      (xfer),
        .shift_o     (shift),
        .setup_o     (setup_o),
        .param_bit_o (param_bit_o)
    );

    // Next state: finish once the final registered setup pulse has reached the chain
    always_comb begin
        state_d   = state_q;
        startLoad = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start_i) begin
                    state_d   = ST_LOAD;
                    startLoad = 1'b1;
                end
            end
            ST_LOAD: begin
                if (setup_o && (bitCnt_q == BIT_W'(TOTAL_BITS))) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit and byte counters restart whenever a new load begins
    always_comb begin
        bitCnt_d  = bitCnt_q;
        byteCnt_d = byteCnt_q;
        if (startLoad) begin
            bitCnt_d  = '0;
            byteCnt_d = '0;
        end else begin
            if (shift) bitCnt_d  = bitCnt_q + BIT_W'(1);
            if (xfer)  byteCnt_d = byteCnt_q + BYTE_W'(1);
        end
    end

    // State and counter registers; reset discards any partial load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bitCnt_q  <= '0;
            byteCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            byteCnt_q <= byteCnt_d;
        end
    end

    assign busy_o    = loadActive;
    assign loaded_o  = (state_q == ST_READY);
    assign run_o     = loaded_o;
    assign bit_cnt_o = bitCnt_q;
endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: one single-neuron and one four-neuron loader,
// each feeding a behavioural neuron shift chain, driven with random bytes.
module tb_bnn_param_loader;
    import bnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start4 = 1'b0;

    logic       setup1, pbit1, busy1, loaded1, run1;
    logic [3:0] bcnt1;
    logic       setup4, pbit4, busy4, loaded4, run4;
    logic [5:0] bcnt4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural neuron chains and observed serial streams
    logic [10:0] chain1;
    logic [43:0] chain4;
    logic [63:0] seq1 = '0;
    logic [63:0] seq4 = '0;
    int setupCnt1 = 0;
    int setupCnt4 = 0;

    // Host-side transfer state shared by the driver and the reference model
    logic [7:0] txBytes[$];
    int txIdx = 0;
    int loadedCyc = 0;
    int firstXferCyc = 0;

    bnn_param_loader_if #(.DATA_W(8)) if1 ();
    bnn_param_loader_if #(.DATA_W(8)) if4 ();

    bnn_param_loader #(.NEURONS(1), .INPUTS(8), .BIAS_BITS(3), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .bus(if1),
        .setup_o(setup1), .param_bit_o(pbit1), .busy_o(busy1),
        .loaded_o(loaded1), .run_o(run1), .bit_cnt_o(bcnt1)
    );

    bnn_param_loader #(.NEURONS(4), .INPUTS(8), .BIAS_BITS(3), .DATA_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .bus(if4),
        .setup_o(setup4), .param_bit_o(pbit4), .busy_o(busy4),
        .loaded_o(loaded4), .run_o(run4), .bit_cnt_o(bcnt4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Neuron chains shift on every setup cycle, param_in entering neuron 0
    always @(negedge clk) begin
        if (setup1) begin
            chain1 = {chain1[9:0], pbit1};
            seq1   = {seq1[62:0], pbit1};
            setupCnt1++;
        end
        if (setup4) begin
            chain4 = {chain4[42:0], pbit4};
            seq4   = {seq4[62:0], pbit4};
            setupCnt4++;
        end
    end

    // Reference model: the i-th bit of the host stream, MSB of each byte first
    function automatic logic bitAt(input int i);
        logic [7:0] b;
        b = txBytes[i / 8];
        return b[7 - (i % 8)];
    endfunction

    // First bits land deepest: neuron k of n holds stream bits 11*(n-1-k) onward
    function automatic logic [10:0] expNeuron(input int k, input int n);
        logic [10:0] v;
        int j;
        v = '0;
        j = n - 1 - k;
        for (int b = 0; b < 11; b++) v = {v[9:0], bitAt(11 * j + b)};
        return v;
    endfunction

    function automatic logic [63:0] expSeq(input int total);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < total; i++) v = {v[62:0], bitAt(i)};
        return v;
    endfunction

    function automatic logic getReady(input int sel);
        return (sel == 1) ? if1.s_ready : if4.s_ready;
    endfunction

    function automatic logic getLoaded(input int sel);
        return (sel == 1) ? loaded1 : loaded4;
    endfunction

    function automatic int getBitCnt(input int sel);
        return (sel == 1) ? int'(bcnt1) : int'(bcnt4);
    endfunction

    task automatic setValid(input int sel, input logic v, input logic [7:0] d);
        if (sel == 1) begin
            if1.s_valid = v;
            if1.s_data  = d;
        end else begin
            if4.s_valid = v;
            if4.s_data  = d;
        end
    endtask

    task automatic waitNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic newBytes(input int count);
        txBytes.delete();
        txIdx = 0;
        repeat (count) txBytes.push_back(8'($urandom));
    endtask

    task automatic pulseStart(input int sel);
        waitNeg();
        if (sel == 1) start1 = 1'b1; else start4 = 1'b1;
        waitNeg();
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Feed txBytes; mode 0 back-to-back, 1 valid every other cycle, 2 random valid.
    // Stops when loaded rises, or when bit_cnt reaches stopBits (if nonzero).
    task automatic applyStimulus(input int sel, input int mode, input int stopBits, input int budget);
        logic v;
        logic tog;
        int waited;
        tog = 1'b1;
        waited = 0;
        while (1'b1) begin
            waitNeg();
            if (getLoaded(sel)) begin
                loadedCyc = cyc;
                setValid(sel, 1'b0, 8'h00);
                break;
            end
            if (stopBits > 0 && getBitCnt(sel) >= stopBits) begin
                setValid(sel, 1'b0, 8'h00);
                break;
            end
            if (waited >= budget) begin
                checks++;
                errors++;
                $display("[TB] FAIL timeout sel=%0d: observed bit_cnt=%0d loaded=0, required loaded=1",
                         sel, getBitCnt(sel));
                setValid(sel, 1'b0, 8'h00);
                break;
            end
            waited++;
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (txIdx >= txBytes.size()) v = 1'b0;
            setValid(sel, v, v ? txBytes[txIdx] : 8'h00);
            if (v && getReady(sel)) begin
                if (txIdx == 0) firstXferCyc = cyc + 1;
                txIdx++;
            end
        end
    endtask

    task automatic checkChain4(input string tag);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("%s_neuron%0d", tag, k), 64'(chain4[k*11 +: 11]), 64'(expNeuron(k, 4)));
    endtask

    initial begin
        int s0;
        int bc;
        setValid(1, 1'b0, 8'h00);
        setValid(4, 1'b0, 8'h00);

        // Reset state
        #2;
        checkOutput("reset_dut4", {57'd0, setup4, pbit4, busy4, loaded4, run4, if4.s_ready, 1'b0} | 64'(bcnt4), 64'd0);
        checkOutput("reset_dut1", {57'd0, setup1, pbit1, busy1, loaded1, run1, if1.s_ready, 1'b0} | 64'(bcnt1), 64'd0);
        waitNeg();
        waitNeg();
        rst_n = 1'b1;

        // Single neuron, two bytes back-to-back
        $display("[TB] single neuron load");
        txBytes.delete();
        txIdx = 0;
        txBytes.push_back(8'hA5);
        txBytes.push_back(8'hE0);
        s0 = setupCnt1;
        pulseStart(1);
        applyStimulus(1, 0, 0, 100);
        checkOutput("n1_setup_cycles", 64'(setupCnt1 - s0), 64'd11);
        checkOutput("n1_bit_stream", 64'(seq1[10:0]), expSeq(11));
        checkOutput("n1_bias", 64'(chain1[10:8]), 64'(3'b101));
        checkOutput("n1_weights", 64'(chain1[7:0]), 64'h2F);
        checkOutput("n1_load_latency", 64'(loadedCyc - firstXferCyc), 64'd12);
        checkOutput("n1_ready_after", 64'(if1.s_ready), 64'd0);
        checkOutput("n1_done_flags", {60'd0, run1, busy1, setup1, 1'b0} | 64'(bcnt1) << 4, (64'd11 << 4) | 64'd8);

        // Four neurons, valid toggling every other cycle
        $display("[TB] four neuron load, sparse valid");
        newBytes(6);
        s0 = setupCnt4;
        pulseStart(4);
        applyStimulus(4, 1, 0, 300);
        checkOutput("n4_setup_cycles", 64'(setupCnt4 - s0), 64'd44);
        checkOutput("n4_bit_cnt", 64'(bcnt4), 64'd44);
        checkOutput("n4_flags", {60'd0, loaded4, run4, busy4, setup4}, 64'b1100);
        checkOutput("n4_bit_stream", 64'(seq4[43:0]), expSeq(44));
        checkChain4("n4");

        // Reset in the middle of a load
        $display("[TB] reset during load");
        newBytes(6);
        pulseStart(4);
        applyStimulus(4, 0, 20, 100);
        checkOutput("mid_bit_cnt", 64'(bcnt4), 64'd20);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_dut4", {57'd0, setup4, pbit4, busy4, loaded4, run4, if4.s_ready, 1'b0} | 64'(bcnt4), 64'd0);
        checkOutput("async_reset_dut1_loaded", 64'(loaded1), 64'd0);
        waitNeg();
        rst_n = 1'b1;
        newBytes(6);
        s0 = setupCnt4;
        pulseStart(4);
        applyStimulus(4, 2, 0, 400);
        checkOutput("rl_setup_cycles", 64'(setupCnt4 - s0), 64'd44);
        checkOutput("rl_loaded", 64'(loaded4), 64'd1);
        checkChain4("rl");

        // start during LOAD is ignored
        $display("[TB] start during load and in ready");
        newBytes(6);
        pulseStart(4);
        applyStimulus(4, 0, 15, 100);
        bc = int'(bcnt4);
        start4 = 1'b1;
        waitNeg();
        start4 = 1'b0;
        checkOutput("ign_busy_loaded", {62'd0, busy4, loaded4}, 64'b10);
        checkOutput("ign_bit_cnt_kept", 64'(int'(bcnt4) >= bc && bc >= 15), 64'd1);
        applyStimulus(4, 1, 0, 300);
        checkOutput("ign_bit_cnt", 64'(bcnt4), 64'd44);
        checkChain4("ign");

        // start in READY restarts the load
        start4 = 1'b1;
        waitNeg();
        start4 = 1'b0;
        checkOutput("restart_state", {62'd0, loaded4, busy4}, 64'b01);
        checkOutput("restart_bit_cnt", 64'(bcnt4), 64'd0);
        newBytes(6);
        applyStimulus(4, 2, 0, 400);
        checkOutput("restart_bit_cnt_done", 64'(bcnt4), 64'd44);
        checkChain4("restart");

        // Extra byte held valid after a complete load
        $display("[TB] extra bytes after load");
        setValid(4, 1'b1, 8'hFF);
        s0 = setupCnt4;
        for (int i = 0; i < 12; i++) begin
            waitNeg();
            checkOutput($sformatf("extra_%0d", i), {60'd0, if4.s_ready, setup4, loaded4, run4}, 64'b0011);
        end
        checkOutput("extra_no_shift", 64'(setupCnt4 - s0), 64'd0);
        checkChain4("extra");

        // Simultaneous start and valid in READY: the byte is not taken
        start4 = 1'b1;
        setValid(4, 1'b1, 8'h5A);
        checkOutput("sim_ready", 64'(if4.s_ready), 64'd0);
        waitNeg();
        start4 = 1'b0;
        setValid(4, 1'b0, 8'h00);
        newBytes(6);
        applyStimulus(4, 0, 0, 200);
        checkOutput("sim_loaded", 64'(loaded4), 64'd1);
        checkChain4("sim");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
